// File: rtl/cntry_car_detector_pkg.sv
// Shared encodings for the country-road detector and the signal controller.
//   RED/YELLOW/GREEN : country-road signal codes driven by the controller
//   TRUE/FALSE       : single-bit logic constants
//   db_state_t       : loop debounce FSM states
package cntry_car_detector_pkg;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RISE_WAIT = 2'd1,
    PRESENT   = 2'd2,
    FALL_WAIT = 2'd3
  } db_state_t;

endpackage

// File: rtl/loop_debouncer.sv
// Loop sensor conditioning: two-flop synchronizer followed by a debounce FSM.
// A loop edge is accepted after DEBOUNCE consecutive equal synchronized samples.
// Ports:
//   clock      - system clock, rising edge
//   clear      - asynchronous active-low reset
//   loop_raw   - raw loop sensor, asynchronous to clock
//   arrive     - registered one-cycle pulse per accepted car
//   arrive_evt - combinational strobe: arrive will be 1 after the coming edge
//   db_state   - debounce FSM state (only with STUCK_DETECT_EN)
module loop_debouncer
  import cntry_car_detector_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic      clock,
  input  logic      clear,
  input  logic      loop_raw,
  output logic      arrive,
  output logic      arrive_evt
`ifdef STUCK_DETECT_EN
  ,
  output db_state_t db_state
`endif
);

  localparam logic [3:0] DC_LAST = 4'(DEBOUNCE - 1);

  logic      sync1;
  logic      s;
  db_state_t state;
  db_state_t state_nxt;
  logic [3:0] dc;
  logic [3:0] dc_nxt;
  logic      arrive_nxt;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      sync1  <= 1'b0;
      s      <= 1'b0;
      state  <= IDLE;
      dc     <= '0;
      arrive <= FALSE;
    end else begin
      sync1  <= loop_raw;
      s      <= sync1;
      state  <= state_nxt;
      dc     <= dc_nxt;
      arrive <= arrive_nxt;
    end
  end

  // With DEBOUNCE=1 the wait states are skipped entirely.
  always_comb begin
    state_nxt  = state;
    dc_nxt     = dc;
    arrive_nxt = FALSE;
    case (state)
      IDLE: begin
        if (s) begin
          if (DEBOUNCE == 1) begin
            state_nxt  = PRESENT;
            dc_nxt     = '0;
            arrive_nxt = TRUE;
          end else begin
            state_nxt = RISE_WAIT;
            dc_nxt    = 4'd1;
          end
        end
      end
      RISE_WAIT: begin
        if (!s) begin
          state_nxt = IDLE;
          dc_nxt    = '0;
        end else if (dc == DC_LAST) begin
          state_nxt  = PRESENT;
          dc_nxt     = '0;
          arrive_nxt = TRUE;
        end else begin
          dc_nxt = dc + 4'd1;
        end
      end
      PRESENT: begin
        if (!s) begin
          if (DEBOUNCE == 1) begin
            state_nxt = IDLE;
            dc_nxt    = '0;
          end else begin
            state_nxt = FALL_WAIT;
            dc_nxt    = 4'd1;
          end
        end
      end
      FALL_WAIT: begin
        if (s) begin
          state_nxt = PRESENT;
          dc_nxt    = '0;
        end else if (dc == DC_LAST) begin
          state_nxt = IDLE;
          dc_nxt    = '0;
        end else begin
          dc_nxt = dc + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        dc_nxt    = '0;
      end
    endcase
  end

  assign arrive_evt = arrive_nxt;

`ifdef STUCK_DETECT_EN
  assign db_state = state;
`endif

endmodule

// File: rtl/cntry_car_detector.sv
// Country-road car detector: debounces the loop sensor, queues arriving cars
// and retires one car every PASS_CYCLES cycles of country-road GREEN.
// Optional feature macro: STUCK_DETECT_EN (loop held high STUCK_CYCLES
// PRESENT cycles flags a failed sensor and empties the queue).
// Ports:
//   clock     - system clock, rising edge
//   clear     - asynchronous active-low reset
//   loop_raw  - raw loop sensor, asynchronous to clock
//   cntry     - country signal from controller (RED/YELLOW/GREEN; 3 = not GREEN)
//   x         - registered car-present request, equals car_count != 0
//   car_count - queued cars, saturating at 2^CNT_W-1
//   arrive    - one-cycle pulse per accepted car
//   stuck     - sensor fault flag (0 without STUCK_DETECT_EN)
module cntry_car_detector
  import cntry_car_detector_pkg::*;
#(
  parameter int unsigned DEBOUNCE     = 3,
  parameter int unsigned PASS_CYCLES  = 4,
  parameter int unsigned CNT_W        = 4
`ifdef STUCK_DETECT_EN
  ,
  parameter int unsigned STUCK_CYCLES = 64
`endif
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             loop_raw,
  input  logic [1:0]       cntry,
  output logic             x,
  output logic [CNT_W-1:0] car_count,
  output logic             arrive,
  output logic             stuck
);

  localparam logic [3:0] PC_LAST = 4'(PASS_CYCLES - 1);

  logic             arrive_evt;
  logic             arr_ok;
  logic             force_clr;
  logic             green;
  logic             has_car;
  logic             depart;
  logic [3:0]       pc;
  logic [3:0]       pc_nxt;
  logic [CNT_W-1:0] count_nxt;

`ifdef STUCK_DETECT_EN
  db_state_t db_state;
`endif

  loop_debouncer #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debouncer (
    .clock      (clock),
    .clear      (clear),
    .loop_raw   (loop_raw),
    .arrive     (arrive),
    .arrive_evt (arrive_evt)
`ifdef STUCK_DETECT_EN
    ,
    .db_state   (db_state)
`endif
  );

`ifdef STUCK_DETECT_EN
  localparam int unsigned SC_W = $clog2(STUCK_CYCLES) + 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STUCK_CYCLES - 1);

  logic [SC_W-1:0] sc;
  logic            stuck_set;

  assign stuck_set = (db_state == PRESENT) && !stuck && (sc == SC_LAST);

  // The fault holds until the loop debounces back to IDLE.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      sc    <= '0;
      stuck <= FALSE;
    end else if (db_state == IDLE) begin
      sc    <= '0;
      stuck <= FALSE;
    end else if (stuck_set) begin
      stuck <= TRUE;
    end else if ((db_state == PRESENT) && !stuck) begin
      sc <= sc + 1'b1;
    end
  end

  assign arr_ok    = arrive_evt & ~stuck;
  assign force_clr = stuck_set;
`else
  assign stuck     = FALSE;
  assign arr_ok    = arrive_evt;
  assign force_clr = FALSE;
`endif

  assign green   = (cntry == GREEN);
  assign has_car = (car_count != '0);
  assign depart  = green && has_car && (pc == PC_LAST);

  always_comb begin
    pc_nxt = pc + 4'd1;
    if (!green || !has_car || depart) pc_nxt = '0;
  end

  // Counter reacts to the arrive strobe so car_count, x and arrive move together.
  always_comb begin
    count_nxt = car_count;
    case ({arr_ok, depart})
      2'b10:   count_nxt = (car_count == '1) ? car_count : car_count + 1'b1;
      2'b01:   count_nxt = car_count - 1'b1;
      default: count_nxt = car_count;
    endcase
    if (force_clr) count_nxt = '0;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      pc        <= '0;
      car_count <= '0;
      x         <= FALSE;
    end else begin
      pc        <= pc_nxt;
      car_count <= count_nxt;
      x         <= (count_nxt != '0);
    end
  end

endmodule

// File: tb/tb_cntry_car_detector.sv
// Self-checking bench for cntry_car_detector. A sample-window model predicts
// arrivals from the last DEBOUNCE synchronized loop samples, and a GREEN-run
// counter predicts departures; outputs are compared on every falling edge.
module tb_cntry_car_detector;

  localparam int DEB  = 3;
  localparam int PASS = 4;
  localparam int CW   = 4;
  localparam int STK  = 64;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic          loop_raw = 1'b0;
  logic [1:0]    cntry = 2'd0;
  logic          x;
  logic [CW-1:0] car_count;
  logic          arrive;
  logic          stuck;

  int checks = 0;
  int failures = 0;
  int arrive_seen = 0;

  cntry_car_detector #(
    .DEBOUNCE     (DEB),
    .PASS_CYCLES  (PASS),
    .CNT_W        (CW)
`ifdef STUCK_DETECT_EN
    ,
    .STUCK_CYCLES (STK)
`endif
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .loop_raw  (loop_raw),
    .cntry     (cntry),
    .x         (x),
    .car_count (car_count),
    .arrive    (arrive),
    .stuck     (stuck)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int hist[0:19];   // hist[i]: loop_raw sampled i edges ago
  bit m_level;      // debounced loop level
  int m_count;
  int green_run;
  int present_run;
  bit m_arr;
  bit m_stuck;
  bit m_x;

  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < 20; i++) hist[i] = 0;
      m_level = 0; m_count = 0; green_run = 0; present_run = 0;
      m_arr = 0; m_stuck = 0; m_x = 0;
    end else begin
      bit all1, all0, in_present, dep, arr, sset, stuck_pre, arr_eff;
      for (int i = 19; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = int'(loop_raw);
      // synchronizer delay of two edges: the window is hist[2 .. DEB+1]
      all1 = 1; all0 = 1;
      for (int i = 2; i < DEB + 2; i++) begin
        if (hist[i] == 0) all1 = 0;
        else all0 = 0;
      end
      in_present = m_level && (hist[3] == 1);
      stuck_pre = m_stuck;
      sset = 0;
`ifdef STUCK_DETECT_EN
      if (!m_level) begin
        present_run = 0;
        m_stuck = 0;
      end else if (in_present && !stuck_pre) begin
        if (present_run == STK - 1) begin
          m_stuck = 1;
          sset = 1;
        end else begin
          present_run++;
        end
      end
`endif
      arr = 0;
      if (!m_level && all1) begin
        m_level = 1;
        arr = 1;
      end else if (m_level && all0) begin
        m_level = 0;
      end
      dep = (cntry == 2'd2) && (m_count > 0) && (green_run == PASS - 1);
      green_run = ((cntry == 2'd2) && (m_count > 0) && !dep) ? green_run + 1 : 0;
      arr_eff = arr && !stuck_pre;
      if (sset) m_count = 0;
      else if (arr_eff && !dep) m_count = (m_count < CMAX) ? m_count + 1 : CMAX;
      else if (dep && !arr_eff) m_count = m_count - 1;
      m_arr = arr;
      m_x = (m_count != 0);
    end
  end

  // ---------------- cycle compare ----------------
  always @(negedge clock) begin
    if (clear) begin
      check("cyc_x", int'(x), int'(m_x));
      check("cyc_count", int'(car_count), m_count);
      check("cyc_arrive", int'(arrive), int'(m_arr));
      check("cyc_stuck", int'(stuck), int'(m_stuck));
      if (arrive) arrive_seen++;
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic car();
    loop_raw = 1'b1;
    wait_neg(6);
    loop_raw = 1'b0;
    wait_neg(6);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    #40 clear = 1'b1;
    wait_neg(15);                          // t=190
    check("rst_x", int'(x), 0);
    check("rst_count", int'(car_count), 0);
    check("rst_arrive", int'(arrive), 0);
    check("rst_stuck", int'(stuck), 0);
    wait_neg(1);                           // t=200
    loop_raw = 1'b1;
    wait_neg(4);                           // t=240
    check("arr_early", int'(arrive), 0);
    wait_neg(1);                           // t=250: first high sample 205, +4 edges
    check("arr_pulse", int'(arrive), 1);
    check("arr_count", int'(car_count), 1);
    check("arr_x", int'(x), 1);
    wait_neg(1);
    check("arr_one_cycle", int'(arrive), 0);
    wait_neg(4);                           // t=300
    loop_raw = 1'b0;
    wait_neg(20);                          // t=500
    loop_raw = 1'b1;
    wait_neg(2);                           // t=520
    loop_raw = 1'b0;
    wait_neg(10);
    check("glitch_count", int'(car_count), 1);
    check("glitch_arrivals", arrive_seen, 1);

    car(); car();
    check("dep_start", int'(car_count), 3);
    cntry = 2'd2;
    wait_neg(3);
    check("dep_hold", int'(car_count), 3);
    wait_neg(1);
    check("dep_first", int'(car_count), 2);
    wait_neg(4);
    check("dep_second", int'(car_count), 1);
    wait_neg(4);
    check("dep_last", int'(car_count), 0);
    check("dep_x_low", int'(x), 0);
    cntry = 2'd0;
    car(); car(); car();
    cntry = 2'd2;
    wait_neg(6);
    cntry = 2'd1;
    wait_neg(2);
    check("yellow_count", int'(car_count), 2);
    cntry = 2'd2;
    wait_neg(3);
    check("pc_restart", int'(car_count), 2);
    wait_neg(1);
    check("pc_after4", int'(car_count), 1);
    cntry = 2'd0;

    car();
    check("sim_pre", int'(car_count), 2);
    loop_raw = 1'b1;                       // arrive edge lines up with 4th GREEN edge
    wait_neg(1);
    cntry = 2'd2;
    wait_neg(4);
    check("sim_arrive", int'(arrive), 1);
    check("sim_count", int'(car_count), 2);
    cntry = 2'd3;                          // illegal code behaves as not-GREEN
    wait_neg(1);
    loop_raw = 1'b0;
    wait_neg(6);
    check("illegal_cntry", int'(car_count), 2);
    cntry = 2'd0;

    repeat (17) car();
    check("sat_count", int'(car_count), CMAX);
    check("sat_x", int'(x), 1);

    loop_raw = 1'b1;
    wait_neg(2);
    #3 clear = 1'b0;
    #1;
    check("async_x", int'(x), 0);
    check("async_count", int'(car_count), 0);
    check("async_arrive", int'(arrive), 0);
    check("async_stuck", int'(stuck), 0);
    loop_raw = 1'b0;
    wait_neg(1);
    clear = 1'b1;
    wait_neg(5);
    check("post_rst_count", int'(car_count), 0);

    loop_raw = 1'b1;
    wait_neg(70);
`ifdef STUCK_DETECT_EN
    check("stuck_flag", int'(stuck), 1);
    check("stuck_count", int'(car_count), 0);
    check("stuck_x", int'(x), 0);
`else
    check("held_flag", int'(stuck), 0);
    check("held_count", int'(car_count), 1);
    check("held_x", int'(x), 1);
`endif
    loop_raw = 1'b0;
    wait_neg(10);
    check("release_stuck", int'(stuck), 0);
`ifdef STUCK_DETECT_EN
    check("release_count", int'(car_count), 0);
`else
    check("release_count", int'(car_count), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
